divisor_secuencial: RTL and testbench
=====================================

// Module: divisor_secuencial
// PURPOSE
//  Sequential restoring divider, the inverse of the ALU's shift-add multiplier: unsigned N-bit Dividendo / Divisor.
//  One quotient bit per clock; start/finish handshake on Init/Done, matching the multiplier.
//  Sits beside the ALU datapath as the division unit; results feed the ALU output mux.
// PARAMETERS
//  N      4   operand width; Cociente and Residuo are N bits each
// PORTS
//  Clk        in   1  system clock, all state on rising edge
//  Rst        in   1  synchronous, active-high reset
//  Init       in   1  start request, level-sampled in IDLE
//  Dividendo  in   N  dividend A, captured on the accepted Init
//  Divisor    in   N  divisor B, captured on the accepted Init
//  Cociente   out  N  quotient, registered
//  Residuo    out  N  remainder, registered
//  Done       out  1  result valid, registered
//  DivCero    out  1  divide-by-zero flag, registered; valid while Done=1
// BEHAVIOUR
//  Interface: one clock (Clk); Rst synchronous, active-high. Rst=1 at an edge forces IDLE and zeroes all outputs and registers.
//  States: IDLE, CALC, FIN.
//  IDLE, Init=1:
//   - Latch Dividendo into shift reg Q and Divisor into D; clear R (N+1 bits); set cnt=N.
//   - D==0: go to FIN; Cociente={N{1}}, Residuo=Dividendo, DivCero=1.
//   - Otherwise: go to CALC; DivCero=0.
//  CALC, each cycle:
//   - {R,Q} <= {R,Q}<<1.
//   - trial = R_shifted - {1'b0,D}.
//   - trial MSB=0: R<=trial, Q[0]<=1. Otherwise R kept (restore), Q[0]<=0.
//   - cnt<=cnt-1. When cnt reaches 1, go to FIN on the same edge.
//  FIN:
//   - Done=1; Cociente=Q, Residuo=R[N-1:0].
//   - Stay while Init=1; go to IDLE on the first edge with Init=0.
//  Latency: Init sampled at edge k -> Done=1 after edge k+N+1 (DivCero path: after edge k+1).
//  Done stays high in FIN only and drops to 0 on the FIN->IDLE edge.
//  Cociente, Residuo and DivCero hold their last values in IDLE until the next accepted Init.
//  Init held high across FIN does not restart. A new operation needs Init low for at least one cycle, then high.
//  Init changes and operand changes during CALC are ignored; operands are used only as captured.
//  Widths: remainder work reg is N+1 bits so trial sign is exact; no overflow possible for unsigned.
//  Invariant on completion (D!=0): Dividendo == Cociente*Divisor + Residuo, with Residuo < Divisor.
//  Rst mid-CALC or in FIN:
//   - Abort; next state IDLE; outputs 0 from the following cycle.
//   - No Done pulse for the aborted op.
//  Rst and Init both high: Rst wins.
// STRUCTURE
//  Shared include div_defs.vh: state encodings (IDLE=2'd0, CALC=2'd1, FIN=2'd2) and counter width $clog2(N+1).
//  FSM, counter and shift registers live in this module.
//  One sub-module: etapa_resta, the combinational trial subtract.
//   - Inputs: R_shifted (N+1 bits), D (N bits).
//   - Outputs: next R, quotient bit.
//   - Built in the same style as the existing N-bit subtractor.
//  Unused state 2'd3 returns to IDLE.
// TESTING (N=4)
//  13/3:  Init 1 cycle -> after 5 edges Done=1, Cociente=4, Residuo=1, DivCero=0.
//  15/1 -> Cociente=15, Residuo=0; 3/9 -> Cociente=0, Residuo=3; 0/5 -> Cociente=0, Residuo=0.
//  7/0:   Done=1 one edge after Init; DivCero=1, Cociente=15, Residuo=7.
//  Init held high 10 cycles on 9/2: exactly one Done; Done stays high until Init=0.
//   - Result Cociente=4, Residuo=1; no second operation starts.
//  Rst=1 during 2nd CALC cycle of 14/3: Done never rises; outputs 0.
//   - A following 14/3 run gives Cociente=4, Residuo=2 at full latency.
//  Exhaustive random: all 256 operand pairs back-to-back.
//   - Check the invariant, DivCero==(B==0), and latency N+1.
//   - Change operands mid-CALC; results must match the captured operands.

Source files
------------

// File: rtl/divisor_secuencial_pkg.sv
`default_nettype none
// =============================================================================
// divisor_secuencial_pkg : shared state encoding and sizing for the divider
// Rev 1.0
// =============================================================================
package divisor_secuencial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_secuencial_etapa_resta.sv
`default_nettype none
// =============================================================================
// etapa_resta : one restoring-division step (trial subtract and restore)
// Rev 1.0
// =============================================================================
module etapa_resta #(
  parameter int N = 4
) (
  input  logic [N:0]   r_shifted,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0] trial;

  assign trial = r_shifted - {1'b0, d};
  assign q_bit = ~trial[N];
  // Either branch is below D, so the restored remainder always fits in N bits.
  assign r_next = q_bit ? trial[N-1:0] : r_shifted[N-1:0];

endmodule
`default_nettype wire

// File: rtl/divisor_secuencial.sv
`default_nettype none
// =============================================================================
// divisor_secuencial : unsigned restoring divider, one quotient bit per clock
// Rev 1.0
// =============================================================================
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Init,
  input  logic [N-1:0] Dividendo,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Cociente,
  output logic [N-1:0] Residuo,
  output logic         Done,
  output logic         DivCero
);

  localparam int CW = cnt_width(N);

  state_t       state;
  logic [N-1:0] q;
  logic [N-1:0] d;
  logic [N-1:0] r;
  logic [CW-1:0] cnt;

  logic [N:0]   r_shifted;
  logic [N-1:0] r_next;
  logic         q_bit;

  assign r_shifted = {r, q[N-1]};

  etapa_resta #(.N(N)) u_etapa_resta (
    .r_shifted (r_shifted),
    .d         (d),
    .r_next    (r_next),
    .q_bit     (q_bit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      cnt      <= '0;
      Cociente <= '0;
      Residuo  <= '0;
      Done     <= 1'b0;
      DivCero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Init) begin
            d   <= Divisor;
            cnt <= CW'(N);
            if (Divisor == '0) begin
              // Preload the divide-by-zero result so FIN publishes it unchanged.
              q       <= '1;
              r       <= Dividendo;
              DivCero <= 1'b1;
              state   <= S_FIN;
            end else begin
              q       <= Dividendo;
              r       <= '0;
              DivCero <= 1'b0;
              state   <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r   <= r_next;
          q   <= {q[N-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_FIN;
          end
        end

        S_FIN: begin
          // First FIN cycle publishes the result; leave only once it was seen.
          if (!Done) begin
            Done     <= 1'b1;
            Cociente <= q;
            Residuo  <= r;
          end else if (!Init) begin
            Done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
`default_nettype none
// =============================================================================
// tb_divisor_secuencial : scoreboard bench for the sequential divider (N=4)
// Rev 1.0
// =============================================================================
module tb_divisor_secuencial;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Init;
  logic [N-1:0] Dividendo;
  logic [N-1:0] Divisor;
  logic [N-1:0] Cociente;
  logic [N-1:0] Residuo;
  logic         Done;
  logic         DivCero;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_q   = 1'b0;

  always #5 Clk = ~Clk;

  divisor_secuencial #(.N(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Init      (Init),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Cociente  (Cociente),
    .Residuo   (Residuo),
    .Done      (Done),
    .DivCero   (DivCero)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation on every rising edge of Done.
  always @(negedge Clk) begin
    if (!Rst && Done && !done_q) begin
      chk("pending_result", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("cociente", Cociente, mon_e.q);
        chk("residuo", Residuo, mon_e.r);
        chk("divcero", DivCero, mon_e.dz);
        if (!mon_e.dz) begin
          chk("invariant", int'(Cociente) * int'(mon_e.b) + int'(Residuo), mon_e.a);
          chk("residuo_lt_divisor", int'(Residuo < mon_e.b), 1);
        end
      end
    end
    done_q = Done;
  end

  // hold: edges after acceptance during which Init stays high.
  // scr: pulse Init and scramble operands while the division is running.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input int hold, input bit scr);
    int lat;
    @(posedge Clk); #1;
    Dividendo = a;
    Divisor   = b;
    Init      = 1'b1;
    sb.push_back('{a: a, b: b, q: eq, r: er, dz: edz});
    @(posedge Clk); #1;
    lat = 0;
    if (hold == 0) Init = 1'b0;
    while (!Done && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (lat >= hold) Init = 1'b0;
      if (scr && lat == 2) begin
        Init      = 1'b1;
        Dividendo = ~a;
        Divisor   = ~b;
      end
    end
    chk("latency", lat, edz ? 1 : N + 1);
    while (Init) begin
      @(posedge Clk); #1;
      lat++;
      chk("done_held", Done, 1);
      if (lat >= hold || lat > 40) Init = 1'b0;
    end
    @(posedge Clk); #1;
    chk("done_drop", Done, 0);
  endtask

  initial begin
    logic any_done;
    Rst       = 1'b1;
    Init      = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("reset_done", Done, 0);
    chk("reset_cociente", Cociente, 0);
    chk("reset_residuo", Residuo, 0);
    chk("reset_divcero", DivCero, 0);

    do_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 0, 1'b0);
    do_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 0, 1'b0);
    do_op(4'd3,  4'd9, 4'd0,  4'd3, 1'b0, 0, 1'b0);
    do_op(4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 0, 1'b0);
    do_op(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 0, 1'b0);
    do_op(4'd9,  4'd2, 4'd4,  4'd1, 1'b0, 10, 1'b0);

    // Abort 14/3 with reset sampled on the second CALC edge.
    @(posedge Clk); #1;
    Dividendo = 4'd14;
    Divisor   = 4'd3;
    Init      = 1'b1;
    @(posedge Clk); #1;
    Init = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("abort_cociente", Cociente, 0);
    chk("abort_residuo", Residuo, 0);
    chk("abort_divcero", DivCero, 0);
    any_done = Done;
    repeat (8) begin
      @(posedge Clk); #1;
      any_done = any_done | Done;
    end
    chk("abort_no_done", any_done, 0);

    do_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_op(a[3:0], 4'd0, 4'hF, a[3:0], 1'b1, 0, 1'b1);
        else        do_op(a[3:0], b[3:0], 4'(a / b), 4'(a % b), 1'b0, 0, 1'b1);
      end
    end

    repeat (2) @(posedge Clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
